// File: rtl/ipml_prefetch_fifo_sc_v2_0.sv
// Single-clock first-word-fall-through FIFO: synchronous-read RAM backed by a
// 2-entry register output stage fed under a credit rule, plus flush, level and threshold flags.
module ipml_prefetch_fifo_sc_v2_0 #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int AFULL_LVL  = 1020,
    parameter int AEMPTY_LVL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W+1:0] level,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   RAM_FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   PTR_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W+1:0] LVL_ONE   = (ADDR_W+2)'(1);
    localparam logic [ADDR_W+1:0] AFULL_TH  = (ADDR_W+2)'(AFULL_LVL);
    localparam logic [ADDR_W+1:0] AEMPTY_TH = (ADDR_W+2)'(AEMPTY_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] stage0;
    logic [DATA_W-1:0] stage1;
    logic [1:0]        stage_cnt;
    logic              inflight;
    logic              in_ready_q;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   wr_ptr_next;
    logic [ADDR_W:0]   rd_ptr_next;
    logic [ADDR_W:0]   ram_cnt;
    logic [ADDR_W:0]   ram_cnt_next;
    logic [ADDR_W+1:0] level_next;
    logic [2:0]        credit;
    logic              push;
    logic              pop;
    logic              issue;
    logic              capture;

    // Valid/ready on both sides: a word moves only on the edge where valid and ready
    // are both high; valid without ready simply waits, nothing is dropped or flagged.
    assign in_ready  = in_ready_q & ~flush;
    assign out_valid = (stage_cnt != 2'd0);
    assign out_data  = stage0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~flush;
    assign capture   = inflight & ~flush;
    assign ram_cnt   = wr_ptr - rd_ptr;

    // Stage words plus the one in flight, net of this cycle's pop, must stay below two.
    assign credit = {1'b0, stage_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue  = ~flush & (ram_cnt != '0) & (credit < 3'd2);

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        level_next  = level;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (push)  wr_ptr_next = wr_ptr + PTR_ONE;
            if (issue) rd_ptr_next = rd_ptr + PTR_ONE;
            if (push && !pop)      level_next = level + LVL_ONE;
            else if (pop && !push) level_next = level - LVL_ONE;
        end
        ram_cnt_next = wr_ptr_next - rd_ptr_next;
    end

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push)  mem[wr_ptr[ADDR_W-1:0]] <= in_data;
        if (issue) ram_q <= mem[rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            inflight     <= 1'b0;
            in_ready_q   <= 1'b0;
            level        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            inflight     <= issue;
            in_ready_q   <= (ram_cnt_next != RAM_FULL);
            level        <= level_next;
            almost_full  <= (level_next >= AFULL_TH);
            almost_empty <= (level_next <= AEMPTY_TH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage0    <= '0;
            stage1    <= '0;
            stage_cnt <= 2'd0;
        end else if (flush) begin
            stage_cnt <= 2'd0;
        end else begin
            case ({capture, pop})
                2'b10: begin
                    if (stage_cnt == 2'd0) stage0 <= ram_q;
                    else                   stage1 <= ram_q;
                    stage_cnt <= stage_cnt + 2'd1;
                end
                2'b01: begin
                    stage0    <= stage1;
                    stage_cnt <= stage_cnt - 2'd1;
                end
                2'b11: begin
                    if (stage_cnt == 2'd1) begin
                        stage0 <= ram_q;
                    end else begin
                        stage0 <= stage1;
                        stage1 <= ram_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ipml_prefetch_fifo_sc_v2_0.sv
// Bench for ipml_prefetch_fifo_sc_v2_0: directed and random traffic, scored
// against a queue model of the stored words and a pushes-minus-pops level count.
module tb_ipml_prefetch_fifo_sc_v2_0;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int AFULL    = 14;
    localparam int AEMPTY   = 4;
    localparam int FULL_LVL = (1 << ADDR_W) + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W+1:0] level;
    logic              almost_full;
    logic              almost_empty;

    logic [DATA_W-1:0] exp_q[$];
    int                t_q[$];
    int                model_level = 0;
    int                cyc = 0;
    int                n_vec = 0;
    int                n_err = 0;
    bit                stream_mode = 0;
    bit                hold = 0;
    logic [DATA_W-1:0] hold_data = '0;

    ipml_prefetch_fifo_sc_v2_0 #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_LVL(AFULL), .AEMPTY_LVL(AEMPTY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired or event missing (t=%0t)", name, $time);
    endfunction

    // scoreboard / monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            t_q.delete();
            model_level = 0;
            hold = 0;
            chk("rst_level", 64'(level), 64'(0));
            chk("rst_out_valid", 64'(out_valid), 64'(0));
        end else begin
            cyc++;
            chk("level", 64'(level), 64'(model_level));
            chk("almost_full", 64'(almost_full), 64'(model_level >= AFULL));
            chk("almost_empty", 64'(almost_empty), 64'(model_level <= AEMPTY));
            if (model_level == FULL_LVL) chk("full_in_ready", 64'(in_ready), 64'(0));
            if (hold) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_data", 64'(out_data), 64'(hold_data));
            end
            if (flush) begin
                chk("flush_in_ready", 64'(in_ready), 64'(0));
                exp_q.delete();
                t_q.delete();
                model_level = 0;
                hold = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail("pop_from_empty_model");
                    end else begin
                        logic [DATA_W-1:0] e;
                        int t;
                        e = exp_q.pop_front();
                        t = t_q.pop_front();
                        chk("pop_data", 64'(out_data), 64'(e));
                        if (stream_mode) chk("stream_latency", 64'(cyc - t), 64'(3));
                    end
                    model_level--;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(in_data);
                    t_q.push_back(cyc);
                    model_level++;
                end
                hold = out_valid && !out_ready;
                hold_data = out_data;
            end
        end
    end

    // driver tasks
    task automatic push_n(input int n, input logic [DATA_W-1:0] base, output int cycles);
        int cnt = 0;
        cycles = 0;
        in_valid = 1'b1;
        in_data = base;
        while (cnt < n && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            if (in_ready) cnt++;
            @(posedge clk);
            #1;
            in_data = base + DATA_W'(cnt);
        end
        in_valid = 1'b0;
        if (cnt < n) fail("push_timeout");
    endtask

    task automatic wait_level0(input int max);
        int k = 0;
        @(negedge clk);
        while (level != '0 && k < max) begin
            @(negedge clk);
            k++;
        end
        if (level != '0) fail("drain_timeout");
    endtask

    initial begin
        int used;
        int pushed;
        int guard;
        bit seen;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;

        // reset values
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", 64'(in_ready), 64'(0));
            chk("rst_out_data", 64'(out_data), 64'(0));
            chk("rst_almost_empty", 64'(almost_empty), 64'(1));
            chk("rst_almost_full", 64'(almost_full), 64'(0));
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); chk("in_ready_before_edge", 64'(in_ready), 64'(0));
        @(negedge clk); chk("in_ready_after_edge", 64'(in_ready), 64'(1));

        // single word fall-through and hold
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data = 32'hA5A5_A5A5;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); chk("fwft_e0", 64'(out_valid), 64'(0));
        @(negedge clk); chk("fwft_e1", 64'(out_valid), 64'(0));
        @(negedge clk); chk("fwft_e2", 64'(out_valid), 64'(1));
        chk("fwft_data", 64'(out_data), 64'(32'hA5A5_A5A5));
        repeat (5) @(negedge clk);
        chk("held_data", 64'(out_data), 64'(32'hA5A5_A5A5));
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        chk("single_pop_valid", 64'(out_valid), 64'(0));
        chk("single_pop_level", 64'(level), 64'(0));

        // fill to capacity, refused push, drain
        @(posedge clk); #1;
        push_n(FULL_LVL, 0, used);
        @(negedge clk);
        chk("full_level", 64'(level), 64'(FULL_LVL));
        chk("full_afull", 64'(almost_full), 64'(1));
        chk("full_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data = 32'h99;
        repeat (4) begin
            @(negedge clk);
            chk("refused_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 3 && !seen; k++) begin
            @(negedge clk);
            seen = in_ready;
        end
        if (!seen) fail("in_ready_recover");
        wait_level0(60);
        @(posedge clk); #1 out_ready = 1'b0;

        // streaming with both sides always ready
        stream_mode = 1;
        out_ready = 1'b1;
        push_n(1000, 32'h1000, used);
        chk("stream_cycles", 64'(used), 64'(1000));
        wait_level0(20);
        stream_mode = 0;
        @(posedge clk); #1 out_ready = 1'b0;

        // random handshakes
        pushed = 0;
        guard = 0;
        while (pushed < 10000 && guard < 80000) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data = $urandom();
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) pushed++;
            guard++;
        end
        if (pushed < 10000) fail("random_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_level0(60);
        @(posedge clk); #1 out_ready = 1'b0;

        // flush with a simultaneous pop
        push_n(9, 32'h100, used);
        repeat (3) @(negedge clk);
        chk("pre_flush_level", 64'(level), 64'(9));
        @(posedge clk); #1;
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_flush_level", 64'(level), 64'(0));
        chk("post_flush_valid", 64'(out_valid), 64'(0));
        repeat (3) @(negedge clk);
        chk("post_flush_quiet", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        push_n(1, 32'h1, used);
        out_ready = 1'b1;
        wait_level0(20);
        @(posedge clk); #1 out_ready = 1'b0;

        // asynchronous reset mid-operation
        push_n(5, 32'h200, used);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_level", 64'(level), 64'(0));
        chk("async_rst_valid", 64'(out_valid), 64'(0));
        chk("async_rst_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("after_rst_valid", 64'(out_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
